// File: rtl/a10_xcvr_recfg_pkg.sv
// a10_xcvr_recfg_pkg
//   Shared definitions for the reconfiguration-port arbiter:
//   - state_t      : arbiter FSM states (IDLE, BUSY)
//   - MAX_MASTERS  : upper bound on the number of requesters
//   - PTR_W        : width of a master index / last-granted pointer
//   - rr_pick()    : round-robin winner from a request vector and the
//                    last-granted pointer (one-hot, all-zero if no request)
package a10_xcvr_recfg_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int PTR_W       = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Search starts at last+1 and wraps at n-1 -> 0, so the master granted
    // last time is examined last. Offsets beyond n are ignored, which keeps
    // the loop bound constant for any n in 2..MAX_MASTERS.
    function automatic logic [MAX_MASTERS-1:0] rr_pick(
        input logic [MAX_MASTERS-1:0] req,
        input logic [PTR_W-1:0]       last,
        input logic [PTR_W:0]         n
    );
        logic [MAX_MASTERS-1:0] win;
        logic [PTR_W:0]         idx;
        logic                   found;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            idx = {1'b0, last} + (PTR_W+1)'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!found && ((PTR_W+1)'(k) <= n) && req[idx[PTR_W-1:0]]) begin
                win[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/a10_xcvr_rr_picker.sv
// a10_xcvr_rr_picker
//   Combinational round-robin picker.
//   Ports:
//     req    in  NMASTERS  request vector
//     ptr    in  PTR_W     index of the master granted last
//     winner out NMASTERS  one-hot selected master (zero when no request)
//     valid  out 1         at least one master is requesting
module a10_xcvr_rr_picker
    import a10_xcvr_recfg_pkg::*;
#(
    parameter int NMASTERS = 2
) (
    input  logic [NMASTERS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [NMASTERS-1:0] winner,
    output logic                valid
);

    logic [MAX_MASTERS-1:0] req_ext;
    logic [MAX_MASTERS-1:0] win_ext;

    always_comb begin
        req_ext                 = '0;
        req_ext[NMASTERS-1:0]   = req;
    end

    assign win_ext = rr_pick(req_ext, ptr, (PTR_W+1)'(NMASTERS));
    assign winner  = win_ext[NMASTERS-1:0];
    // Bits above NMASTERS are never set, so OR-ing the whole vector is exact.
    assign valid   = |win_ext;

endmodule

// File: rtl/a10_xcvr_recfg_arbiter.sv
// a10_xcvr_recfg_arbiter
//   Round-robin arbiter sharing one Arria 10 transceiver/PLL reconfiguration
//   Avalon-MM slave between NMASTERS (2..8) requesters in the reconfig clock
//   domain. A master keeps the grant across transfers while m_lock is high.
//   Ports:
//     clk, reset          reconfig clock, synchronous active-high reset
//     m_address/m_write/m_writedata/m_read/m_lock   per-master command (packed)
//     m_readdata/m_waitrequest                      per-master response (packed)
//     s_address/s_write/s_writedata/s_read          to reconfig slave
//     s_readdata/s_waitrequest                      from reconfig slave
//     grant               one-hot current owner, zero when idle
//     fsm_state           arbiter state (0 = IDLE, 1 = BUSY) for observation
//
//   Handshake: Avalon-MM without readdatavalid. A transfer completes on the
//   cycle where (read | write) & !waitrequest; read data is valid in that same
//   cycle. A master holds its strobes, address and data while waitrequest = 1.
module a10_xcvr_recfg_arbiter
    import a10_xcvr_recfg_pkg::*;
#(
    parameter int NMASTERS = 2,
    parameter int AWIDTH   = 10,
    parameter int DWIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NMASTERS*AWIDTH-1:0]   m_address,
    input  logic [NMASTERS-1:0]          m_write,
    input  logic [NMASTERS*DWIDTH-1:0]   m_writedata,
    input  logic [NMASTERS-1:0]          m_read,
    input  logic [NMASTERS-1:0]          m_lock,
    output logic [NMASTERS*DWIDTH-1:0]   m_readdata,
    output logic [NMASTERS-1:0]          m_waitrequest,
    output logic [AWIDTH-1:0]            s_address,
    output logic                         s_write,
    output logic [DWIDTH-1:0]            s_writedata,
    output logic                         s_read,
    input  logic [DWIDTH-1:0]            s_readdata,
    input  logic                         s_waitrequest,
    output logic [NMASTERS-1:0]          grant,
    output logic                         fsm_state
);

    state_t                state;
    logic [PTR_W-1:0]      last_ptr;
    logic [NMASTERS-1:0]   req;
    logic [NMASTERS-1:0]   pick;
    logic                  pick_valid;
    logic [PTR_W-1:0]      g_idx;
    logic                  g_read;
    logic                  g_write;
    logic                  g_lock;
    logic                  release_now;

    assign req       = m_read | m_write | m_lock;
    assign fsm_state = state;

    a10_xcvr_rr_picker #(
        .NMASTERS (NMASTERS)
    ) u_picker (
        .req    (req),
        .ptr    (last_ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    // Index and strobes of the current owner (all zero when grant is zero).
    always_comb begin
        g_idx   = '0;
        g_read  = 1'b0;
        g_write = 1'b0;
        g_lock  = 1'b0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (grant[i]) begin
                g_idx   = PTR_W'(i);
                g_read  = m_read[i];
                g_write = m_write[i];
                g_lock  = m_lock[i];
            end
        end
    end

    // Give up the port after an unlocked completion, or when the owner has
    // nothing to do and no lock.
    assign release_now = (state == BUSY) && !g_lock &&
                         (!(g_read || g_write) || !s_waitrequest);

    // Command/response steering. Read+write together forwards only the write.
    always_comb begin
        s_address     = '0;
        s_write       = 1'b0;
        s_read        = 1'b0;
        s_writedata   = '0;
        m_waitrequest = '1;
        m_readdata    = '0;
        if (state == BUSY) begin
            for (int i = 0; i < NMASTERS; i++) begin
                if (grant[i]) begin
                    s_address                      = m_address[i*AWIDTH +: AWIDTH];
                    s_write                        = m_write[i];
                    s_read                         = m_read[i] & ~m_write[i];
                    s_writedata                    = m_writedata[i*DWIDTH +: DWIDTH];
                    m_waitrequest[i]               = s_waitrequest;
                    m_readdata[i*DWIDTH +: DWIDTH] = s_readdata;
                end
            end
        end
    end

    // Pointer resets to NMASTERS-1 so master 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            last_ptr <= PTR_W'(NMASTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        grant    <= '0;
                        last_ptr <= g_idx;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a10_xcvr_recfg_arbiter.sv
// tb_a10_xcvr_recfg_arbiter
//   Cycle-by-cycle vector table for a 2-master arbiter, followed by a long
//   lock-hold sequence. Inputs change on the falling edge; outputs are
//   compared 1 ns later. Completed slave writes are matched against an
//   expected queue, and read+write from the owner is counted as a violation.
module tb_a10_xcvr_recfg_arbiter;

    localparam int NM = 2;
    localparam int AW = 10;
    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_address;
    logic [NM-1:0]    m_write;
    logic [NM*DW-1:0] m_writedata;
    logic [NM-1:0]    m_read;
    logic [NM-1:0]    m_lock;
    logic [NM*DW-1:0] m_readdata;
    logic [NM-1:0]    m_waitrequest;
    logic [AW-1:0]    s_address;
    logic             s_write;
    logic [DW-1:0]    s_writedata;
    logic             s_read;
    logic [DW-1:0]    s_readdata;
    logic             s_waitrequest;
    logic [NM-1:0]    grant;
    logic             fsm_state;

    a10_xcvr_recfg_arbiter #(
        .NMASTERS (NM),
        .AWIDTH   (AW),
        .DWIDTH   (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_read        (m_read),
        .m_lock        (m_lock),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_read        (s_read),
        .s_readdata    (s_readdata),
        .s_waitrequest (s_waitrequest),
        .grant         (grant),
        .fsm_state     (fsm_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_viol   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [1:0]  wr, rd, lk;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        swait;
        logic [31:0] srd;
        logic [1:0]  eg;
        logic        esw, esr;
        logic [9:0]  esa;
        logic [31:0] eswd;
        logic [1:0]  emw;
        logic [31:0] erd0, erd1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] wr, input logic [1:0] rd, input logic [1:0] lk,
        input logic [9:0] a0, input logic [9:0] a1, input logic [31:0] d0, input logic [31:0] d1,
        input logic swait, input logic [31:0] srd,
        input logic [1:0] eg, input logic esw, input logic esr, input logic [9:0] esa,
        input logic [31:0] eswd, input logic [1:0] emw, input logic [31:0] erd0, input logic [31:0] erd1);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rd = rd; v.lk = lk; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.swait = swait; v.srd = srd; v.eg = eg; v.esw = esw; v.esr = esr; v.esa = esa;
        v.eswd = eswd; v.emw = emw; v.erd0 = erd0; v.erd1 = erd1;
        return v;
    endfunction

    // ---------------- scoreboard: completed slave writes ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_w;

    always @(posedge clk) begin
        if (!reset && s_write && !s_waitrequest) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL slave_write: unexpected write addr %h data %h", s_address, s_writedata);
            end else begin
                exp_w = exp_q.pop_front();
                if ({s_address, s_writedata} !== exp_w) begin
                    n_errors++;
                    $display("FAIL slave_write: got addr %h data %h expected addr %h data %h",
                             s_address, s_writedata, exp_w[AW+DW-1:DW], exp_w[DW-1:0]);
                end
            end
        end
    end

    // Protocol checker: owner driving read and write at once.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NM; i++) begin
                if (grant[i] && m_read[i] && m_write[i]) begin
                    n_viol++;
                    $display("protocol violation: master %0d drove read and write together", i);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic got;

        reset = 1'b1; m_address = '0; m_write = '0; m_writedata = '0; m_read = '0; m_lock = '0;
        s_readdata = '0; s_waitrequest = 1'b0;

        exp_q.push_back({10'h100, 32'h0000_00A5});
        exp_q.push_back({10'h010, 32'h0000_0011});
        exp_q.push_back({10'h020, 32'h0000_0022});
        exp_q.push_back({10'h010, 32'h0000_0011});
        exp_q.push_back({10'h020, 32'h0000_0022});
        exp_q.push_back({10'h000, 32'h0000_0055});
        exp_q.push_back({10'h030, 32'h0000_0033});
        exp_q.push_back({10'h030, 32'h0000_0033});
        exp_q.push_back({10'h0F0, 32'h0000_0077});
        exp_q.push_back({10'h030, 32'h0000_0033});

        //                rst wr     rd     lk     a0      a1      d0     d1     sw  srd            | eg   sw  sr  sa      swd    mw     rd0 rd1
        // reset state
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0, 0, 32'h0,         2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        // single write from master 0, slave stalls two cycles
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h100, 10'h000, 32'hA5, 32'h0, 1, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h100, 10'h000, 32'hA5, 32'h0, 1, 32'h0,        2'b01, 1, 0, 10'h100, 32'hA5, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h100, 10'h000, 32'hA5, 32'h0, 1, 32'h0,        2'b01, 1, 0, 10'h100, 32'hA5, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h100, 10'h000, 32'hA5, 32'h0, 0, 32'h0,        2'b01, 1, 0, 10'h100, 32'hA5, 2'b10, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h100, 10'h000, 32'hA5, 32'h0, 0, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        // read from master 1, zero-wait slave
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, 10'h000, 10'h480, 32'h0, 32'h0, 0, 32'h12345678, 2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, 10'h000, 10'h480, 32'h0, 32'h0, 0, 32'h12345678, 2'b10, 0, 1, 10'h480, 32'h0, 2'b01, 0, 32'h12345678));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h000, 10'h480, 32'h0, 32'h0, 0, 32'h12345678, 2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        // contention: both masters write continuously -> 0, 1, 0, 1
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b01, 1, 0, 10'h010, 32'h11, 2'b10, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b10, 1, 0, 10'h020, 32'h22, 2'b01, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b01, 1, 0, 10'h010, 32'h11, 2'b10, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b10, 1, 0, 10'h020, 32'h22, 2'b01, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h010, 10'h020, 32'h11, 32'h22, 0, 32'h0,      2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        // lock: master 1 read, idle, write 0x000 while master 0 requests
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b10, 10'h030, 10'h040, 32'h33, 32'h0, 0, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b10, 10'h030, 10'h040, 32'h33, 32'h0, 0, 32'hCAFE0001, 2'b10, 0, 1, 10'h040, 32'h0, 2'b01, 0, 32'hCAFE0001));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b10, 10'h030, 10'h000, 32'h33, 32'h0, 0, 32'h0,        2'b10, 0, 0, 10'h000, 32'h0, 2'b01, 0, 0));
        vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 10'h030, 10'h000, 32'h33, 32'h55, 0, 32'h0,       2'b10, 1, 0, 10'h000, 32'h55, 2'b01, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h030, 10'h000, 32'h33, 32'h55, 0, 32'h0,       2'b10, 0, 0, 10'h000, 32'h55, 2'b01, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h030, 10'h000, 32'h33, 32'h55, 0, 32'h0,       2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b00, 2'b00, 10'h030, 10'h000, 32'h33, 32'h55, 0, 32'h0,       2'b01, 1, 0, 10'h030, 32'h33, 2'b10, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h030, 10'h000, 32'h33, 32'h55, 0, 32'h0,       2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        // reset while master 1 read is stalled, then master 0 has priority
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, 10'h030, 10'h080, 32'h33, 32'h0, 1, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(1, 2'b00, 2'b10, 2'b00, 10'h030, 10'h080, 32'h33, 32'h0, 1, 32'h0,        2'b10, 0, 1, 10'h080, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b00, 10'h030, 10'h080, 32'h33, 32'h0, 1, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b10, 2'b00, 10'h030, 10'h080, 32'h33, 32'h0, 0, 32'h0,        2'b01, 1, 0, 10'h030, 32'h33, 2'b10, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, 10'h030, 10'h080, 32'h33, 32'h0, 0, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 2'b00, 10'h030, 10'h080, 32'h33, 32'h0, 0, 32'h00000BAD, 2'b10, 0, 1, 10'h080, 32'h0, 2'b01, 0, 32'h00000BAD));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h030, 10'h080, 32'h33, 32'h0, 0, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        // illegal read+write from master 0: only the write is forwarded
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, 10'h0F0, 10'h000, 32'h77, 32'h0, 0, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));
        vecs.push_back(mk(0, 2'b01, 2'b01, 2'b00, 10'h0F0, 10'h000, 32'h77, 32'h0, 0, 32'h0,        2'b01, 1, 0, 10'h0F0, 32'h77, 2'b10, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 10'h0F0, 10'h000, 32'h77, 32'h0, 0, 32'h0,        2'b00, 0, 0, 10'h000, 32'h0, 2'b11, 0, 0));

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset         = vecs[i].rst;
            m_write       = vecs[i].wr;
            m_read        = vecs[i].rd;
            m_lock        = vecs[i].lk;
            m_address     = {vecs[i].a1, vecs[i].a0};
            m_writedata   = {vecs[i].d1, vecs[i].d0};
            s_waitrequest = vecs[i].swait;
            s_readdata    = vecs[i].srd;
            #1;
            check($sformatf("v%0d grant", i),         32'(grant),         32'(vecs[i].eg));
            check($sformatf("v%0d fsm_state", i),     32'(fsm_state),     32'(vecs[i].eg != 2'b00));
            check($sformatf("v%0d s_write", i),       32'(s_write),       32'(vecs[i].esw));
            check($sformatf("v%0d s_read", i),        32'(s_read),        32'(vecs[i].esr));
            check($sformatf("v%0d s_address", i),     32'(s_address),     32'(vecs[i].esa));
            check($sformatf("v%0d s_writedata", i),   s_writedata,        vecs[i].eswd);
            check($sformatf("v%0d m_waitrequest", i), 32'(m_waitrequest), 32'(vecs[i].emw));
            check($sformatf("v%0d m_readdata0", i),   m_readdata[31:0],   vecs[i].erd0);
            check($sformatf("v%0d m_readdata1", i),   m_readdata[63:32],  vecs[i].erd1);
        end

        // Long lock hold: master 1 owns the port with no transfers for 20
        // cycles while master 0 keeps requesting; no timeout may steal it.
        @(negedge clk);
        reset = 1'b0; m_lock = 2'b10; m_write = 2'b00; m_read = 2'b00;
        s_waitrequest = 1'b0; s_readdata = '0;
        m_address = {10'h000, 10'h030}; m_writedata = {32'h0, 32'h33};
        #1;
        check("lock_req grant_idle", 32'(grant), 32'h0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            m_write = 2'b01;
            #1;
            check($sformatf("lock_hold%0d grant", k), 32'(grant), 32'h2);
            check($sformatf("lock_hold%0d m0_wait", k), 32'(m_waitrequest[0]), 32'h1);
        end
        @(negedge clk);
        m_lock = 2'b00;
        #1;
        check("lock_drop grant", 32'(grant), 32'h2);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 5 && !got; k++) begin
            @(negedge clk);
            #1;
            if (grant == 2'b01) begin
                got = 1'b1;
                lat = k;
            end
        end
        check("lock_to_m0_grant cycles", 32'(lat), 32'd2);
        @(negedge clk);
        m_write = 2'b00;
        #1;
        check("after_m0_write grant", 32'(grant), 32'h0);

        @(negedge clk);
        check("protocol_violations", 32'(n_viol), 32'd1);
        check("write_queue_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
